// File: rtl/smt_fetch_unit_if.sv
// Fetch-unit handshake bundle: hazard/predictor/redirect inputs and fetch outputs.
// master drives the fetch unit's inputs, slave is the fetch unit itself.
interface smt_fetch_unit_if #(
  parameter int ADDRESS_WIDTH = 32
);
  logic                     i_Stall;
  logic [3:0]               i_thread_active;
  logic                     i_bp_taken;
  logic [ADDRESS_WIDTH-1:0] i_bp_target;
  logic                     i_Redirect;
  logic [1:0]               i_Redirect_thread;
  logic [ADDRESS_WIDTH-1:0] i_Redirect_PC;
  logic [ADDRESS_WIDTH-1:0] o_PC;
  logic [1:0]               o_thread;
  logic                     o_fetch_valid;
  logic                     o_prediction;
  logic [ADDRESS_WIDTH-1:0] o_branch_target;
  logic                     o_Flush;

  modport master (
    output i_Stall, i_thread_active, i_bp_taken, i_bp_target,
           i_Redirect, i_Redirect_thread, i_Redirect_PC,
    input  o_PC, o_thread, o_fetch_valid, o_prediction, o_branch_target, o_Flush
  );

  modport slave (
    input  i_Stall, i_thread_active, i_bp_taken, i_bp_target,
           i_Redirect, i_Redirect_thread, i_Redirect_PC,
    output o_PC, o_thread, o_fetch_valid, o_prediction, o_branch_target, o_Flush
  );
endinterface

// File: rtl/smt_fetch_unit.sv
// Four-thread round-robin fetch PC generator with per-thread redirect and flush.
// Optional branch-prediction steering enabled by defining FETCH_BRANCH_PREDICT_EN.
module smt_fetch_unit #(
  parameter int                       ADDRESS_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC         = ADDRESS_WIDTH'(32'h0000_0000),
  parameter logic [ADDRESS_WIDTH-1:0] THREAD_PC_STRIDE = ADDRESS_WIDTH'(32'h0000_1000)
) (
  input logic             i_Clk,
  input logic             i_Reset_n,
  smt_fetch_unit_if.slave fif
);

  logic [3:0][ADDRESS_WIDTH-1:0] pc_reg;
  logic [3:0][ADDRESS_WIDTH-1:0] pc_next;
  logic [1:0]                    sel_reg;
  logic [1:0]                    sel_next;
  logic [1:0]                    last_thr_reg;
  logic                          last_v_reg;
  logic                          flush_reg;

  logic                     advance;
  logic                     fetch_valid;
  logic                     prediction;
  logic [ADDRESS_WIDTH-1:0] cur_pc;
  logic [ADDRESS_WIDTH-1:0] advance_pc;
  logic [ADDRESS_WIDTH-1:0] branch_target;

  assign advance     = ~fif.i_Stall;
  assign cur_pc      = pc_reg[sel_reg];
  assign fetch_valid = fif.i_thread_active[sel_reg];

`ifdef FETCH_BRANCH_PREDICT_EN
  assign prediction    = fif.i_bp_taken & fetch_valid;
  assign branch_target = prediction ? fif.i_bp_target : '0;
  assign advance_pc    = prediction ? fif.i_bp_target : cur_pc + ADDRESS_WIDTH'(4);
`else
  logic unused_bp;
  assign unused_bp     = ^{fif.i_bp_taken, fif.i_bp_target};
  assign prediction    = 1'b0;
  assign branch_target = '0;
  assign advance_pc    = cur_pc + ADDRESS_WIDTH'(4);
`endif

  // Rotate from sel+1; the last candidate is sel itself so a lone active thread repeats.
  always_comb begin
    logic       found;
    logic [1:0] cand;
    sel_next = sel_reg;
    found    = 1'b0;
    cand     = sel_reg;
    for (int k = 1; k <= 4; k++) begin
      cand = sel_reg + 2'(k);
      if (!found && fif.i_thread_active[cand]) begin
        sel_next = cand;
        found    = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pc
      logic adv_hit;
      logic redir_hit;
      assign adv_hit   = advance && fetch_valid && (sel_reg == 2'(gi));
      assign redir_hit = fif.i_Redirect && (fif.i_Redirect_thread == 2'(gi));
      // Redirect beats both the sequential step and a prediction on the same thread.
      assign pc_next[gi] = redir_hit ? fif.i_Redirect_PC :
                           adv_hit   ? advance_pc      : pc_reg[gi];
    end
  endgenerate

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      for (int n = 0; n < 4; n++) begin
        pc_reg[n] <= RESET_PC + THREAD_PC_STRIDE * ADDRESS_WIDTH'(n);
      end
      sel_reg      <= '0;
      last_thr_reg <= '0;
      last_v_reg   <= 1'b0;
      flush_reg    <= 1'b0;
    end else begin
      pc_reg <= pc_next;
      if (advance) begin
        sel_reg      <= sel_next;
        last_thr_reg <= sel_reg;
        last_v_reg   <= fetch_valid;
      end
      // Only the redirected thread's instruction sitting in IF/DEC is squashed.
      flush_reg <= fif.i_Redirect && last_v_reg && (fif.i_Redirect_thread == last_thr_reg);
    end
  end

  assign fif.o_PC            = cur_pc;
  assign fif.o_thread        = sel_reg;
  assign fif.o_fetch_valid   = fetch_valid;
  assign fif.o_prediction    = prediction;
  assign fif.o_branch_target = branch_target;
  assign fif.o_Flush         = flush_reg;

endmodule

// File: tb/tb_smt_fetch_unit.sv
// Directed bench for smt_fetch_unit with a cycle-level reference model and literal checks.
module tb_smt_fetch_unit;

`ifdef FETCH_BRANCH_PREDICT_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  smt_fetch_unit_if #(.ADDRESS_WIDTH(32)) fif ();

  smt_fetch_unit dut (
    .i_Clk     (clk),
    .i_Reset_n (rst_n),
    .fif       (fif)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: thread PCs, pointer, last issue, flush.
  logic [31:0] m_pc [4];
  int          m_sel;
  int          m_last_thr;
  bit          m_last_v;
  bit          m_flush;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) m_pc[n] <= 32'h1000 * n;
      m_sel      <= 0;
      m_last_thr <= 0;
      m_last_v   <= 1'b0;
      m_flush    <= 1'b0;
    end else begin
      automatic bit          fv   = fif.i_thread_active[m_sel];
      automatic bit          pred = PRED_EN && fif.i_bp_taken && fv;
      automatic int          nsel = m_sel;
      automatic bit          got  = 1'b0;
      automatic logic [31:0] npc [4];
      for (int n = 0; n < 4; n++) npc[n] = m_pc[n];
      if (!fif.i_Stall) begin
        if (fv) npc[m_sel] = pred ? fif.i_bp_target : m_pc[m_sel] + 32'd4;
        for (int d = 1; d <= 4; d++) begin
          if (!got && fif.i_thread_active[(m_sel + d) % 4]) begin
            nsel = (m_sel + d) % 4;
            got  = 1'b1;
          end
        end
        m_sel      <= nsel;
        m_last_thr <= m_sel;
        m_last_v   <= fv;
      end
      if (fif.i_Redirect) npc[fif.i_Redirect_thread] = fif.i_Redirect_PC;
      for (int n = 0; n < 4; n++) m_pc[n] <= npc[n];
      m_flush <= fif.i_Redirect && m_last_v && (int'(fif.i_Redirect_thread) == m_last_thr);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    automatic bit e_v = fif.i_thread_active[m_sel];
    automatic bit e_p = PRED_EN && fif.i_bp_taken && e_v;
    chk("mdl_pc",     fif.o_PC, m_pc[m_sel]);
    chk("mdl_thread", 32'(fif.o_thread), 32'(m_sel));
    chk("mdl_valid",  32'(fif.o_fetch_valid), 32'(e_v));
    chk("mdl_pred",   32'(fif.o_prediction), 32'(e_p));
    chk("mdl_target", fif.o_branch_target, e_p ? fif.i_bp_target : 32'h0);
    chk("mdl_flush",  32'(fif.o_Flush), 32'(m_flush));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    fif.i_Stall           = 1'b0;
    fif.i_bp_taken        = 1'b0;
    fif.i_bp_target       = 32'h0;
    fif.i_Redirect        = 1'b0;
    fif.i_Redirect_thread = 2'd0;
    fif.i_Redirect_PC     = 32'h0;
  endtask

  task automatic do_reset(input logic [3:0] mask);
    step();
    rst_n = 1'b0;
    clear_inputs();
    fif.i_thread_active = mask;
    step();
    rst_n = 1'b1;
  endtask

  // Waits for the sampling edge and checks thread/PC/valid literals.
  task automatic at_fetch(input string name, input int thr, input logic [31:0] pc, input bit v);
    @(negedge clk);
    $display("txn %s: thread=%0d pc=%h valid=%0d flush=%0d", name, fif.o_thread, fif.o_PC,
             fif.o_fetch_valid, fif.o_Flush);
    chk({name, "_thread"}, 32'(fif.o_thread), 32'(thr));
    chk({name, "_pc"}, fif.o_PC, pc);
    chk({name, "_valid"}, 32'(fif.o_fetch_valid), 32'(v));
  endtask

  initial begin
    clear_inputs();
    fif.i_thread_active = 4'b0000;
    #12;
    chk("rst_pc", fif.o_PC, 32'h0);
    chk("rst_thread", 32'(fif.o_thread), 32'h0);
    chk("rst_valid", 32'(fif.o_fetch_valid), 32'h0);
    chk("rst_flush", 32'(fif.o_Flush), 32'h0);

    // Full round robin from reset.
    do_reset(4'b1111);
    at_fetch("rr0", 0, 32'h0000, 1'b1); step();
    at_fetch("rr1", 1, 32'h1000, 1'b1); step();
    at_fetch("rr2", 2, 32'h2000, 1'b1); step();
    at_fetch("rr3", 3, 32'h3000, 1'b1); step();
    at_fetch("rr4", 0, 32'h0004, 1'b1); step();

    // Sparse mask, empty mask, single thread, reactivation.
    do_reset(4'b0101);
    at_fetch("alt0", 0, 32'h0000, 1'b1); step();
    at_fetch("alt1", 2, 32'h2000, 1'b1); step();
    at_fetch("alt2", 0, 32'h0004, 1'b1); step();
    at_fetch("alt3", 2, 32'h2004, 1'b1); step();
    fif.i_thread_active = 4'b0000;
    at_fetch("idle0", 0, 32'h0008, 1'b0); step();
    at_fetch("idle1", 0, 32'h0008, 1'b0); step();
    fif.i_thread_active = 4'b0001;
    at_fetch("solo0", 0, 32'h0008, 1'b1); step();
    at_fetch("solo1", 0, 32'h000C, 1'b1); step();
    fif.i_thread_active = 4'b0101;
    at_fetch("react0", 0, 32'h0010, 1'b1); step();
    at_fetch("react1", 2, 32'h2008, 1'b1); step();

    // PC wrap at the top of the address space.
    do_reset(4'b0010);
    fif.i_Redirect = 1'b1; fif.i_Redirect_thread = 2'd1; fif.i_Redirect_PC = 32'hFFFF_FFFC;
    at_fetch("wrap_pre", 0, 32'h0000, 1'b0); step();
    clear_inputs();
    at_fetch("wrap0", 1, 32'hFFFF_FFFC, 1'b1); step();
    at_fetch("wrap1", 1, 32'h0000_0000, 1'b1); step();

    // Taken prediction on thread 0.
    do_reset(4'b0001);
    fif.i_bp_taken = 1'b1; fif.i_bp_target = 32'h200;
    at_fetch("bp0", 0, 32'h0000, 1'b1);
    chk("bp_pred", 32'(fif.o_prediction), 32'(PRED_EN));
    chk("bp_target", fif.o_branch_target, PRED_EN ? 32'h200 : 32'h0);
    step();
    clear_inputs();
    at_fetch("bp1", 0, PRED_EN ? 32'h200 : 32'h4, 1'b1); step();

    // Redirect during stall of the last-issued thread.
    do_reset(4'b1111);
    at_fetch("st0", 0, 32'h0000, 1'b1); step();
    at_fetch("st1", 1, 32'h1000, 1'b1); step();
    at_fetch("st2", 2, 32'h2000, 1'b1); step();
    fif.i_Stall = 1'b1; fif.i_Redirect = 1'b1; fif.i_Redirect_thread = 2'd2; fif.i_Redirect_PC = 32'h80;
    at_fetch("st3", 3, 32'h3000, 1'b1);
    chk("st3_flush", 32'(fif.o_Flush), 32'h0);
    step();
    clear_inputs();
    at_fetch("st4", 3, 32'h3000, 1'b1);
    chk("st4_flush", 32'(fif.o_Flush), 32'h1);
    step();
    at_fetch("st5", 0, 32'h0004, 1'b1);
    chk("st5_flush", 32'(fif.o_Flush), 32'h0);
    step();
    at_fetch("st6", 1, 32'h1004, 1'b1); step();
    at_fetch("st7", 2, 32'h0080, 1'b1); step();

    // Redirect beats prediction, then asynchronous reset mid-sequence.
    do_reset(4'b0001);
    at_fetch("rp0", 0, 32'h0000, 1'b1); step();
    fif.i_Redirect = 1'b1; fif.i_Redirect_thread = 2'd0; fif.i_Redirect_PC = 32'h400;
    fif.i_bp_taken = 1'b1; fif.i_bp_target = 32'h200;
    at_fetch("rp1", 0, 32'h0004, 1'b1);
    chk("rp1_pred", 32'(fif.o_prediction), 32'(PRED_EN));
    step();
    clear_inputs();
    at_fetch("rp2", 0, 32'h0400, 1'b1);
    chk("rp2_flush", 32'(fif.o_Flush), 32'h1);
    #2;
    rst_n = 1'b0;
    fif.i_Stall = 1'b1;
    fif.i_Redirect = 1'b1; fif.i_Redirect_thread = 2'd0; fif.i_Redirect_PC = 32'h999C;
    #1;
    chk("arst_pc", fif.o_PC, 32'h0);
    chk("arst_thread", 32'(fif.o_thread), 32'h0);
    chk("arst_flush", 32'(fif.o_Flush), 32'h0);
    step();
    clear_inputs();
    rst_n = 1'b1;
    at_fetch("post0", 0, 32'h0000, 1'b1); step();
    at_fetch("post1", 0, 32'h0004, 1'b1); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
